lot_checker_n: RTL
==================

Name: lot_checker_n

Overview:
- Parametrised successor to the two-player lottery ticket checker.
- Players alternate tickets. Each ticket is DIGITS digits, entered most-significant first, one per `insere` strobe.
- Each digit is compared positionally against a configurable secret number. The count of matches is graded into a 2-bit prize, and a per-player saturating score is accumulated.
- Sits between the keypad/debounce front end and the display/score logic of the lottery game.

Parameters:
- DIGITS, 5, digits per ticket (>=1).
- NUM_W, 4, bits per digit (BCD).
- SECRET, 20'h47019, secret number; DIGITS*NUM_W bits, digit 0 in the MS nibble.
- SCORE_W, 5, width of each player score.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- fim  in  1  abort current ticket.
- fim_jogo  in  1  end of game; return to idle, scores kept.
- insere  in  1  digit strobe, one digit accepted per cycle high.
- num  in  NUM_W  digit value.
- premio  out  2  prize of last evaluated ticket.
- premio_vld  out  1  one-cycle pulse when premio and score update.
- erro  out  1  one-cycle pulse on invalid digit.
- turno  out  1  owner of current/next ticket (0=p1, 1=p2).
- p1  out  SCORE_W  player 1 score.
- p2  out  SCORE_W  player 2 score.
- lider  out  2  00 tie, 01 p1 ahead, 10 p2 ahead; combinational from p1/p2.

Behaviour:
- Reset (synchronous, active-high), all registered: state=IDLE, idx=0, hits=0, premio=0, premio_vld=0, erro=0, turno=0, p1=0, p2=0.
- Priority per edge: reset > fim_jogo > fim/invalid digit > insere.
- States: IDLE, ENTER, EVAL.
- IDLE:
  - insere accepts digit 0: idx<=1, hits<=(num==SECRET digit 0).
  - Next state is ENTER, or EVAL if DIGITS==1.
- ENTER:
  - Each insere compares num with SECRET digit idx, increments hits on a match, and increments idx.
  - The edge accepting digit DIGITS-1 moves the FSM to EVAL.
  - No insere leaves the state unchanged.
- EVAL (one cycle; insere ignored):
  - Grade: hits==DIGITS gives premio 3 (+4 points).
  - hits==DIGITS-1 gives premio 2 (+2 points).
  - hits==DIGITS-2 with DIGITS>=3 gives premio 1 (+1 point).
  - Otherwise premio 0 (+0 points).
  - Points are added to p1 if turno==0, else p2, saturating at 2^SCORE_W-1.
  - At the same edge: premio_vld<=1, turno toggles, state<=IDLE.
- Latency: last digit sampled at edge E0; premio, premio_vld, score and turno change at E1; premio_vld clears at E2.
- premio holds its value until the next EVAL, abort, or reset.
- Invalid digit (num>9 while insere high, IDLE or ENTER):
  - erro pulses for one cycle.
  - Ticket is aborted as for fim.
- fim in ENTER, or fim while insere is high in IDLE:
  - Ticket aborted: premio<=0, no premio_vld, no score change, turno toggles, state<=IDLE.
  - fim in IDLE with no insere is ignored. fim in EVAL is ignored (the evaluation completes).
- fim_jogo in any state:
  - state<=IDLE, idx<=0, hits<=0, turno<=0, premio<=0.
  - Scores are held. Any in-flight ticket is discarded with no score update.
- Simultaneous fim_jogo with the last insere: fim_jogo wins, so no EVAL occurs.
- Reset mid-ticket clears everything on that edge.
- Widths:
  - idx and hits are $clog2(DIGITS+1) bits.
  - Score addition is done at SCORE_W+1 bits, then clamped.

Test Plan:
- Jackpot: reset, then turno=0 inserts 4,7,0,1,9 on consecutive cycles -> premio_vld pulse one cycle after the 5th digit edge, premio=3, p1=4, turno=1, lider=01.
- Near miss, second player: continuing from the jackpot test, p2 inserts 4,7,0,1,8 -> premio=2, p2=2, turno=0. Then p1 inserts 4,7,5,1,8 -> premio=1, p1=5.
- Abort and invalid digit:
  - p1 inserts 4,7 then asserts fim -> premio=0, no premio_vld, p1 unchanged, turno=1.
  - p2 inserts 4 then num=12 -> erro pulse, abort, turno=0.
- Saturation (SCORE_W=5): p1 scores 8 jackpots (each p2 ticket aborted by fim) -> p1 goes 4,8,...,28 then 31, stays 31. lider=01.
- Game end race: fim_jogo asserted on the same cycle as the 5th digit -> no premio_vld, state IDLE, turno=0, scores unchanged. A following reset -> p1=p2=0, lider=00.
- DIGITS=1, SECRET=4'h7: insere 7 -> premio=3 next edge. insere 3 -> premio=0, premio_vld still pulses.

Source files
------------

// File: rtl/lot_checker_n.sv
// Two-player lottery ticket checker: positional digit match against SECRET,
// graded prize and per-player saturating score.
module lot_checker_n #(
  parameter int DIGITS = 5,
  parameter int NUM_W = 4,
  parameter logic [DIGITS*NUM_W-1:0] SECRET = 20'h47019,
  parameter int SCORE_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fim,
  input  logic               fim_jogo,
  input  logic               insere,
  input  logic [NUM_W-1:0]   num,
  output logic [1:0]         premio,
  output logic               premio_vld,
  output logic               erro,
  output logic               turno,
  output logic [SCORE_W-1:0] p1,
  output logic [SCORE_W-1:0] p2,
  output logic [1:0]         lider
);

  localparam int IDX_W = $clog2(DIGITS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
  localparam logic [SCORE_W:0] SCORE_MAX = {1'b0, {SCORE_W{1'b1}}};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ENTER = 2'd1, S_EVAL = 2'd2} state_t;

  state_t               r_state, w_state_nxt;
  logic [IDX_W-1:0]     r_idx, w_idx_nxt;
  logic [IDX_W-1:0]     r_hits, w_hits_nxt;
  logic [1:0]           r_premio, w_premio_nxt;
  logic                 r_vld, w_vld_nxt;
  logic                 r_erro, w_erro_nxt;
  logic                 r_turno, w_turno_nxt;
  logic [SCORE_W-1:0]   r_p1, w_p1_nxt;
  logic [SCORE_W-1:0]   r_p2, w_p2_nxt;

  logic [DIGITS*NUM_W-1:0] w_secret_sh;
  logic [NUM_W-1:0]        w_secret_dig;
  logic                    w_match;
  logic                    w_bad;
  logic                    w_abort;
  logic [1:0]              w_grade;
  logic [2:0]              w_points;
  logic [SCORE_W:0]        w_sum;
  logic [SCORE_W-1:0]      w_score_sat;

  // Digit idx of the secret sits in the MS nibble once shifted left by idx digits.
  assign w_secret_sh  = SECRET << (r_idx * NUM_W);
  assign w_secret_dig = w_secret_sh[DIGITS*NUM_W-1 -: NUM_W];
  assign w_match      = (num == w_secret_dig);
  assign w_bad        = (num > NUM_W'(9));

  assign w_abort = !fim_jogo &&
                   (((r_state == S_IDLE) && insere && (fim || w_bad)) ||
                    ((r_state == S_ENTER) && (fim || (insere && w_bad))));

  always_comb begin
    w_grade  = 2'd0;
    w_points = 3'd0;
    if (r_hits == IDX_W'(DIGITS)) begin
      w_grade  = 2'd3;
      w_points = 3'd4;
    end else if ((DIGITS >= 2) && (r_hits == IDX_W'(DIGITS - 1))) begin
      w_grade  = 2'd2;
      w_points = 3'd2;
    end else if ((DIGITS >= 3) && (r_hits == IDX_W'(DIGITS - 2))) begin
      w_grade  = 2'd1;
      w_points = 3'd1;
    end else begin
      w_grade  = 2'd0;
      w_points = 3'd0;
    end
  end

  assign w_sum       = (r_turno ? {1'b0, r_p2} : {1'b0, r_p1}) + (SCORE_W + 1)'(w_points);
  assign w_score_sat = (w_sum > SCORE_MAX) ? SCORE_MAX[SCORE_W-1:0] : w_sum[SCORE_W-1:0];

  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_hits_nxt   = r_hits;
    w_premio_nxt = r_premio;
    w_vld_nxt    = 1'b0;
    w_erro_nxt   = 1'b0;
    w_turno_nxt  = r_turno;
    w_p1_nxt     = r_p1;
    w_p2_nxt     = r_p2;
    if (fim_jogo) begin
      w_state_nxt  = S_IDLE;
      w_idx_nxt    = '0;
      w_hits_nxt   = '0;
      w_turno_nxt  = 1'b0;
      w_premio_nxt = 2'd0;
    end else if (w_abort) begin
      w_state_nxt  = S_IDLE;
      w_idx_nxt    = '0;
      w_hits_nxt   = '0;
      w_premio_nxt = 2'd0;
      w_turno_nxt  = ~r_turno;
      w_erro_nxt   = insere && w_bad;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (insere) begin
            w_idx_nxt   = IDX_W'(1);
            w_hits_nxt  = IDX_W'(w_match);
            w_state_nxt = (DIGITS == 1) ? S_EVAL : S_ENTER;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_ENTER: begin
          if (insere) begin
            w_idx_nxt   = r_idx + IDX_W'(1);
            w_hits_nxt  = r_hits + IDX_W'(w_match);
            w_state_nxt = (r_idx == LAST_IDX) ? S_EVAL : S_ENTER;
          end else begin
            w_state_nxt = S_ENTER;
          end
        end
        S_EVAL: begin
          w_premio_nxt = w_grade;
          w_vld_nxt    = 1'b1;
          w_turno_nxt  = ~r_turno;
          w_idx_nxt    = '0;
          w_hits_nxt   = '0;
          w_state_nxt  = S_IDLE;
          if (r_turno) begin
            w_p2_nxt = w_score_sat;
          end else begin
            w_p1_nxt = w_score_sat;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_idx_nxt   = '0;
          w_hits_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_hits   <= '0;
      r_premio <= 2'd0;
      r_vld    <= 1'b0;
      r_erro   <= 1'b0;
      r_turno  <= 1'b0;
      r_p1     <= '0;
      r_p2     <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_hits   <= w_hits_nxt;
      r_premio <= w_premio_nxt;
      r_vld    <= w_vld_nxt;
      r_erro   <= w_erro_nxt;
      r_turno  <= w_turno_nxt;
      r_p1     <= w_p1_nxt;
      r_p2     <= w_p2_nxt;
    end
  end

  assign premio     = r_premio;
  assign premio_vld = r_vld;
  assign erro       = r_erro;
  assign turno      = r_turno;
  assign p1         = r_p1;
  assign p2         = r_p2;
  assign lider      = (r_p1 > r_p2) ? 2'b01 : ((r_p2 > r_p1) ? 2'b10 : 2'b00);

endmodule
